mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Single-port memory arbiter for the pipelined MIPS32 core. The instruction-fetch (IF) stage and the data-access (MEM) stage share one synchronous memory port through this block. It makes one grant per cycle, with data priority and a starvation guard for fetch. Each read response is routed back to the requester that issued it. On a taken branch, fetch responses still in flight are discarded, and the block drives stall signals back to the pipeline.

## Interface
Parameters:
- ADDR_W, 10, word-address width (1024-word memory).
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from an issued read to valid mem_rdata; legal range 1..8.
- STARVE_MAX, 3, consecutive lost cycles after which fetch wins; legal range 1..15.

Ports (clock and reset first):
- clk1  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request; held with if_addr until granted.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data.
- flush_if  in  1  taken branch: kill in-flight fetches, ignore if_req this cycle.
- dm_req  in  1  data request; held with dm_we, dm_addr and dm_wdata until granted.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  load data valid.
- dm_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after a read strobe.
- stall_if  out  1  hold PC and IF_ID.
- stall_mem  out  1  hold EX_MEM and MEM_WB.

## Operation
- Arbitration is combinational within the cycle. Define eff_if = if_req & ~flush_if.
  - Only one requester active: it is granted.
  - Both active: dm wins, unless starve_cnt == STARVE_MAX, in which case if wins.
  - At most one of if_gnt and dm_gnt is high.
- Memory drive:
  - mem_en = if_gnt | dm_gnt.
  - mem_addr and mem_wdata come from the granted requester.
  - mem_we = dm_gnt & dm_we.
  - When mem_en = 0, mem_addr, mem_wdata and mem_we are 0.
- starve_cnt is a 4-bit register:
  - +1 (saturating at STARVE_MAX) when eff_if & ~if_gnt.
  - Cleared on if_gnt.
  - Holds otherwise, including while flush_if is high.
- Tag pipeline: MEM_LAT stages of {valid, owner}. Stage 0 loads valid = mem_en & ~mem_we and owner = IF/DM. The tag shifts every cycle; there is no backpressure.
- Response routing:
  - if_rvalid = last.valid & owner==IF.
  - dm_rvalid = last.valid & owner==DM.
  - Each rdata equals mem_rdata when its rvalid is high, else 0.
- Flush: when flush_if is high, the valid bit of every IF-owned tag in the pipeline is cleared. This includes the tag reaching the last stage that same cycle, so if_rvalid is 0 while flush_if is high. DM tags are untouched.
- Stores get no response. The store is complete at the edge on which it is granted.
- stall_if = eff_if & ~if_gnt.
- stall_mem = (dm_req & ~dm_gnt) | (an outstanding DM read exists whose data has not yet returned).

## Timing
- Reset (rst_n low, asynchronous): all tags invalid and starve_cnt = 0. All outputs are 0 while reset is asserted: gnts, rvalids, rdatas, mem_*, and stalls. Requests are ignored during reset.
- Reset mid-operation: in-flight reads are dropped, and no rvalid is produced for them after rst_n releases.
- Latency: a read granted in cycle t gives rvalid in cycle t+MEM_LAT. Throughput is one access per cycle.
- Handshake: a request that is not granted must be held stable. Deasserting a request without a grant is a protocol violation; the bench flags it.
- Simultaneous flush_if and if_req: if_gnt = 0 and dm is granted if requesting. A dm_req in the same cycle is unaffected.
- Starvation bound: with if_req held and dm_req continuously high, fetch is granted in at most STARVE_MAX+1 cycles.

## Test plan
- Idle, then if_req with if_addr=5 and MEM_LAT=2: if_gnt in cycle 0, mem_addr=5; if_rvalid in cycle 2 with if_rdata = MEM[5]. No stalls.
- if_req and dm_req (load at addr 9) both high from cycle 0, STARVE_MAX=3: dm granted in cycles 0-2 with stall_if=1. In cycle 3 if_gnt=1 and starve_cnt resets. dm_rvalid appears 2 cycles after each dm grant.
- Fetch at addr 4 granted in cycle 0, flush_if high in cycle 1: no if_rvalid in cycle 2. A dm load granted in cycle 1 still returns dm_rvalid in cycle 3.
- Store at addr 7 with data 32'hDEAD_BEEF, then a load at addr 7: mem_we=1 in the store cycle with no rvalid. The load returns 32'hDEAD_BEEF after MEM_LAT cycles, and stall_mem stays high until it does.
- Reads granted in cycles 0 and 1, rst_n pulsed low in cycle 1: all outputs go to 0 immediately. No rvalid appears in cycles 2-4 after release.
- MEM_LAT=1 with back-to-back alternating IF and DM reads: each rvalid appears one cycle after its grant, owners match, and there are no gaps.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mem_port_arbiter                                               |
// | Brief   : shares one synchronous memory port between fetch and data,     |
// |           routes read responses back to their issuer, drives stalls.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              flush_if,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam logic               c_owner_if    = 1'b0;
  localparam logic [3:0]         c_starve_max  = 4'(STARVE_MAX);
  // The youngest MEM_LAT-1 stages hold reads whose data is still outstanding.
  localparam logic [MEM_LAT-1:0] c_pend_mask   = {MEM_LAT{1'b1}} >> 1;

  logic               w_eff_if;
  logic               w_dm_req;
  logic               w_starved;
  logic               w_if_gnt;
  logic               w_dm_gnt;
  logic               w_mem_en;
  logic               w_mem_we;
  logic               w_last_valid;
  logic               w_last_owner;
  logic               w_if_rvalid;
  logic               w_dm_rvalid;
  logic               w_dm_pending;
  logic [3:0]         r_starve_cnt;
  logic [MEM_LAT-1:0] r_tag_valid;
  logic [MEM_LAT-1:0] r_tag_owner;
  logic [MEM_LAT-1:0] w_valid_nxt;
  logic [MEM_LAT-1:0] w_owner_nxt;

  // Requests are qualified with rst_n so every output is 0 while in reset.
  assign w_eff_if  = rst_n & if_req & ~flush_if;
  assign w_dm_req  = rst_n & dm_req;
  assign w_starved = (r_starve_cnt == c_starve_max);
  assign w_if_gnt  = w_eff_if & (~w_dm_req | w_starved);
  assign w_dm_gnt  = w_dm_req & ~w_if_gnt;
  assign w_mem_en  = w_if_gnt | w_dm_gnt;
  assign w_mem_we  = w_dm_gnt & dm_we;

  assign if_gnt    = w_if_gnt;
  assign dm_gnt    = w_dm_gnt;
  assign mem_en    = w_mem_en;
  assign mem_we    = w_mem_we;
  assign mem_addr  = w_if_gnt ? if_addr : (w_dm_gnt ? dm_addr : '0);
  assign mem_wdata = w_dm_gnt ? dm_wdata : '0;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (w_eff_if && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Tag stage 0 captures the access issued this cycle; older tags shift up,
  // losing their valid bit if they belong to fetch and a flush is active.
  assign w_valid_nxt[0] = w_mem_en & ~w_mem_we;
  assign w_owner_nxt[0] = w_dm_gnt;

  for (genvar gi = 1; gi < MEM_LAT; gi++) begin : g_tag_shift
    assign w_valid_nxt[gi] = r_tag_valid[gi-1] &
                             ~(flush_if & (r_tag_owner[gi-1] == c_owner_if));
    assign w_owner_nxt[gi] = r_tag_owner[gi-1];
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_valid <= '0;
      r_tag_owner <= '0;
    end else begin
      r_tag_valid <= w_valid_nxt;
      r_tag_owner <= w_owner_nxt;
    end
  end

  assign w_last_valid = r_tag_valid[MEM_LAT-1];
  assign w_last_owner = r_tag_owner[MEM_LAT-1];

  // A flush also kills the fetch response arriving in the same cycle.
  assign w_if_rvalid = w_last_valid & (w_last_owner == c_owner_if) & ~flush_if;
  assign w_dm_rvalid = w_last_valid & (w_last_owner != c_owner_if);

  assign if_rvalid = w_if_rvalid;
  assign dm_rvalid = w_dm_rvalid;
  assign if_rdata  = w_if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = w_dm_rvalid ? mem_rdata : '0;

  assign w_dm_pending = (w_dm_gnt & ~dm_we) |
                        (|(r_tag_valid & r_tag_owner & c_pend_mask));

  assign stall_if  = w_eff_if & ~w_if_gnt;
  assign stall_mem = (w_dm_req & ~w_dm_gnt) | w_dm_pending;

endmodule
`default_nettype wire
